shift_arbiter: RTL and testbench

Shares one 8-bit logical right barrel shifter (result = A >> B[2:0], zero fill) between two requesters in the K_ALU datapath. Arbitration is round-robin, and each requester has a valid/ready handshake. The block registers the winning operands, drives the external combinational shifter, captures its result and returns it on a single tagged output channel with valid/ready backpressure. It sits between the ALU issue logic and the shifter instance.

---
 rtl/shift_arbiter.sv | 135 +++++++++++++
 tb/tb_shift_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one external 8-bit logical right shifter between two requesters.
// Optional macro SHIFT_ARB_SAT_EN: shift amounts of 8 or more yield 8'h00 instead of B mod 8.
module shift_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r0_valid,
    output logic       r0_ready,
    input  logic [7:0] r0_a,
    input  logic [7:0] r0_b,
    input  logic       r1_valid,
    output logic       r1_ready,
    input  logic [7:0] r1_a,
    input  logic [7:0] r1_b,
    output logic [7:0] sh_a,
    output logic [7:0] sh_b,
    input  logic [7:0] sh_res,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_res,
    output logic       out_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic       last_gnt_r;
    logic [7:0] op_a_r;
    logic [7:0] op_b_r;
    logic       op_id_r;
    logic [7:0] out_res_r;
    logic       out_id_r;
    logic       out_valid_r;

    logic       gnt_id_s;
    logic       accept_s;
    logic [7:0] res_s;

    // Grant selection; ready is gated by rst_n so it drops the instant reset asserts.
    always_comb begin
        gnt_id_s = 1'b0;
        if (r0_valid && r1_valid) begin
            gnt_id_s = ~last_gnt_r;
        end else if (r1_valid) begin
            gnt_id_s = 1'b1;
        end else begin
            gnt_id_s = 1'b0;
        end
        accept_s = rst_n && (state_r == IDLE) && (r0_valid || r1_valid);
        r0_ready = accept_s && !gnt_id_s;
        r1_ready = accept_s && gnt_id_s;
    end

    // Result post-processing applied at capture time.
    always_comb begin
        res_s = sh_res;
`ifdef SHIFT_ARB_SAT_EN
        if (op_b_r[7:3] != 5'd0) begin
            res_s = 8'h00;
        end else begin
            res_s = sh_res;
        end
`endif
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = EXEC;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: state_s = DONE;
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, round-robin pointer and registered result channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_r  <= 1'b1;
            op_a_r      <= 8'h00;
            op_b_r      <= 8'h00;
            op_id_r     <= 1'b0;
            out_res_r   <= 8'h00;
            out_id_r    <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                op_a_r     <= gnt_id_s ? r1_a : r0_a;
                op_b_r     <= gnt_id_s ? r1_b : r0_b;
                op_id_r    <= gnt_id_s;
                last_gnt_r <= gnt_id_s;
            end
            if (state_r == EXEC) begin
                out_res_r   <= res_s;
                out_id_r    <= op_id_r;
                out_valid_r <= 1'b1;
            end else if ((state_r == DONE) && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign sh_a      = op_a_r;
    assign sh_b      = op_b_r;
    assign out_res   = out_res_r;
    assign out_id    = out_id_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: directed vectors push expected {id,res}; a monitor pops on handshake.
module tb_shift_arbiter;

    logic       clk;
    logic       rst_n;
    logic       r0_valid;
    logic       r0_ready;
    logic [7:0] r0_a;
    logic [7:0] r0_b;
    logic       r1_valid;
    logic       r1_ready;
    logic [7:0] r1_a;
    logic [7:0] r1_b;
    logic [7:0] sh_a;
    logic [7:0] sh_b;
    logic [7:0] sh_res;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_res;
    logic       out_id;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_e;

    shift_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .r0_valid (r0_valid),
        .r0_ready (r0_ready),
        .r0_a     (r0_a),
        .r0_b     (r0_b),
        .r1_valid (r1_valid),
        .r1_ready (r1_ready),
        .r1_a     (r1_a),
        .r1_b     (r1_b),
        .sh_a     (sh_a),
        .sh_b     (sh_b),
        .sh_res   (sh_res),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_res  (out_res),
        .out_id   (out_id)
    );

    // External combinational shifter.
    assign sh_res = sh_a >> sh_b[2:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one transfer per cycle where out_valid and out_ready are both high.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got id=%0d res=%0h, expected none", out_id, out_res);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_res", {24'd0, out_res}, {24'd0, mon_e[7:0]});
                chk("out_id", {31'd0, out_id}, {31'd0, mon_e[8]});
            end
        end
    end

    // Present one request, check the ready pulse, and return one cycle after the accept edge.
    task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_res, input logic push);
        r0_valid = !id;
        r1_valid = id;
        r0_a = a; r0_b = b;
        r1_a = a; r1_b = b;
        #1;
        chk("ready_granted", {31'd0, id ? r1_ready : r0_ready}, 32'd1);
        chk("ready_other", {31'd0, id ? r0_ready : r1_ready}, 32'd0);
        if (push) exp_q.push_back({id, exp_res});
        @(posedge clk); #1;
        chk("ready_one_cycle", {30'd0, r0_ready, r1_ready}, 32'd0);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
    endtask

    task automatic wait_out(input int exp_lat);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, exp_lat);
    endtask

    logic [7:0] sweep_exp [8];
    logic [3:0] exp_g;
    int         gnt_seen;
    int         last_t;
    int         budget;

    initial begin
        sweep_exp = '{8'h81, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        rst_n = 1'b0;
        r0_valid = 1'b1; r1_valid = 1'b0;
        r0_a = 8'h00; r0_b = 8'h00; r1_a = 8'h00; r1_b = 8'h00;
        out_ready = 1'b1;
        #12;
        chk("rst_r0_ready", {31'd0, r0_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_res", {24'd0, out_res}, 32'd0);
        chk("rst_out_id", {31'd0, out_id}, 32'd0);
        chk("rst_sh_a", {24'd0, sh_a}, 32'd0);
        chk("rst_sh_b", {24'd0, sh_b}, 32'd0);
        r0_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic single operation.
        issue(1'b0, 8'hB4, 8'h02, 8'h2D, 1'b1);
        chk("exec_sh_a", {24'd0, sh_a}, 32'hB4);
        wait_out(1);
        @(posedge clk); #1;
        chk("back_to_idle", {31'd0, out_valid}, 32'd0);

        // Sweep of shift amounts.
        for (int b = 0; b < 8; b++) begin
            issue(1'b0, 8'h81, b[7:0], sweep_exp[b], 1'b1);
            wait_out(1);
            @(posedge clk); #1;
        end

        // Shift amount of 9.
`ifdef SHIFT_ARB_SAT_EN
        issue(1'b0, 8'hAA, 8'h09, 8'h00, 1'b1);
`else
        issue(1'b0, 8'hAA, 8'h09, 8'h55, 1'b1);
`endif
        wait_out(1);
        @(posedge clk); #1;

        // Backpressure stall with both requesters pending.
        out_ready = 1'b0;
        issue(1'b0, 8'h3C, 8'h02, 8'h0F, 1'b1);
        wait_out(1);
        r0_valid = 1'b1; r1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_res", {24'd0, out_res}, 32'h0F);
            chk("stall_id", {31'd0, out_id}, 32'd0);
            chk("stall_ready", {30'd0, r0_ready, r1_ready}, 32'd0);
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release", {31'd0, out_valid}, 32'd0);
        chk("stall_drained", exp_q.size(), 32'd0);

        // Asynchronous reset while an operation is in EXEC.
        issue(1'b0, 8'hF0, 8'h04, 8'h0F, 1'b0);
        r0_a = 8'hFF; r0_b = 8'h01;
        r1_a = 8'h80; r1_b = 8'h07;
        r0_valid = 1'b1; r1_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_res", {24'd0, out_res}, 32'd0);
        chk("arst_ready", {30'd0, r0_ready, r1_ready}, 32'd0);
        chk("arst_sh_a", {24'd0, sh_a}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("first_tie_r0", {30'd0, r0_ready, r1_ready}, 32'd2);

        // Continuous tie: grants alternate 0,1,0,1 every 3 cycles.
        exp_q.push_back({1'b0, 8'h7F});
        exp_q.push_back({1'b1, 8'h01});
        exp_q.push_back({1'b0, 8'h7F});
        exp_q.push_back({1'b1, 8'h01});
        exp_g = 4'b1010;
        gnt_seen = 0;
        last_t = 0;
        for (int cyc = 0; cyc < 40 && gnt_seen < 4; cyc++) begin
            if (r0_ready || r1_ready) begin
                chk("both_ready", {31'd0, r0_ready & r1_ready}, 32'd0);
                chk("gnt_order", {31'd0, r1_ready}, {31'd0, exp_g[gnt_seen]});
                if (gnt_seen > 0) chk("issue_interval", cyc - last_t, 32'd3);
                last_t = cyc;
                gnt_seen++;
            end
            @(posedge clk); #1;
        end
        chk("gnt_count", gnt_seen, 32'd4);
        r0_valid = 1'b0; r1_valid = 1'b0;
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("final_drained", exp_q.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("final_idle", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
